// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator. It counts the pixel raster, issues pixel-RAM reads one clock
// ahead, and re-aligns sync, blank and colour to the RAM read latency.
module vga_timing_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int H_FP     = 16,
    parameter int V_ACTIVE = 480,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int V_FP     = 10,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int RD_LAT   = 1,
    parameter int CW       = 4
) (
    input  logic            vga_clk,
    input  logic            rst,
    input  logic            en,
    input  logic [3*CW-1:0] d_in,
    output logic [9:0]      row_addr,
    output logic [10:0]     col_addr,
    output logic            rdn,
    output logic [CW-1:0]   r,
    output logic [CW-1:0]   g,
    output logic [CW-1:0]   b,
    output logic            hs,
    output logic            vs,
    output logic            blank,
    output logic            line_start,
    output logic            frame_start
);
    localparam int H_TOT = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOT = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);

    localparam logic [HW-1:0] H_LAST      = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_SYNC_END  = HW'(H_SYNC);
    localparam logic [HW-1:0] H_ACT_START = HW'(H_SYNC + H_BP);
    localparam logic [HW-1:0] H_ACT_END   = HW'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [VW-1:0] V_LAST      = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_SYNC_END  = VW'(V_SYNC);
    localparam logic [VW-1:0] V_ACT_START = VW'(V_SYNC + V_BP);
    localparam logic [VW-1:0] V_ACT_END   = VW'(V_SYNC + V_BP + V_ACTIVE);

    if (RD_LAT < 1 || RD_LAT > 4 ||
        H_ACTIVE < 1 || H_SYNC < 1 || H_BP < 1 || H_FP < 1 ||
        V_ACTIVE < 1 || V_SYNC < 1 || V_BP < 1 || V_FP < 1) begin : gen_param_check
        $fatal(1, "vga_timing_ctrl: RD_LAT must be 1..4 and every timing region non-empty");
    end

    typedef struct packed {
        logic act;
        logic hSync;
        logic vSync;
        logic lineSt;
        logic frameSt;
    } pixFlags_t;

    logic [HW-1:0] hc_q, hc_d;
    logic [VW-1:0] vc_q, vc_d;
    logic          hSyncRaw, vSyncRaw, hAct, vAct, act;
    logic [10:0]   colCalc;
    logic [9:0]    rowCalc;
    logic [9:0]    rowAddr_q, rowAddr_d;
    logic [10:0]   colAddr_q, colAddr_d;
    logic          rdn_q, rdn_d;
    pixFlags_t     flags_d;
    pixFlags_t     dl_q [RD_LAT];
    pixFlags_t     outFlags;
    logic [CW-1:0] r_q, g_q, b_q;
    logic          hs_q, vs_q, blank_q, lineStart_q, frameStart_q;

    // Raster counters; dropping en parks them at the origin so re-enabling starts a fresh frame.
    always_comb begin
        hc_d = hc_q;
        vc_d = vc_q;
        if (!en) begin
            hc_d = '0;
            vc_d = '0;
        end else if (hc_q == H_LAST) begin
            hc_d = '0;
            vc_d = (vc_q == V_LAST) ? '0 : vc_q + 1'b1;
        end else begin
            hc_d = hc_q + 1'b1;
        end
    end

    always_comb begin
        hSyncRaw = hc_q < H_SYNC_END;
        vSyncRaw = vc_q < V_SYNC_END;
        hAct     = (hc_q >= H_ACT_START) && (hc_q < H_ACT_END);
        vAct     = (vc_q >= V_ACT_START) && (vc_q < V_ACT_END);
        act      = hAct && vAct;
        colCalc  = 11'(hc_q) - 11'(H_SYNC + H_BP);
        rowCalc  = 10'(vc_q) - 10'(V_SYNC + V_BP);

        rowAddr_d = '0;
        colAddr_d = '0;
        rdn_d     = 1'b1;
        flags_d   = '0;
        if (en) begin
            rowAddr_d       = rowCalc;
            colAddr_d       = colCalc;
            rdn_d           = ~act;
            flags_d.act     = act;
            flags_d.hSync   = hSyncRaw;
            flags_d.vSync   = vSyncRaw;
            flags_d.lineSt  = act && (colCalc == '0);
            flags_d.frameSt = act && (colCalc == '0) && (rowCalc == '0);
        end
    end

    // Address stage plus a flag delay line matching the RAM latency, so the output stage sees
    // each pixel's flags on the same edge its RAM data arrives.
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            hc_q      <= '0;
            vc_q      <= '0;
            rowAddr_q <= '0;
            colAddr_q <= '0;
            rdn_q     <= 1'b1;
            for (int i = 0; i < RD_LAT; i++) dl_q[i] <= '0;
        end else begin
            hc_q      <= hc_d;
            vc_q      <= vc_d;
            rowAddr_q <= rowAddr_d;
            colAddr_q <= colAddr_d;
            rdn_q     <= rdn_d;
            dl_q[0]   <= flags_d;
            for (int i = 1; i < RD_LAT; i++) dl_q[i] <= dl_q[i-1];
        end
    end

    assign outFlags = dl_q[RD_LAT-1];

    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            r_q          <= '0;
            g_q          <= '0;
            b_q          <= '0;
            hs_q         <= ~HS_POL;
            vs_q         <= ~VS_POL;
            blank_q      <= 1'b1;
            lineStart_q  <= 1'b0;
            frameStart_q <= 1'b0;
        end else begin
            hs_q         <= outFlags.hSync ? HS_POL : ~HS_POL;
            vs_q         <= outFlags.vSync ? VS_POL : ~VS_POL;
            blank_q      <= ~outFlags.act;
            lineStart_q  <= outFlags.lineSt;
            frameStart_q <= outFlags.frameSt;
            if (outFlags.act) begin
                {b_q, g_q, r_q} <= d_in;
            end else begin
                {b_q, g_q, r_q} <= '0;
            end
        end
    end

    assign row_addr    = rowAddr_q;
    assign col_addr    = colAddr_q;
    assign rdn         = rdn_q;
    assign r           = r_q;
    assign g           = g_q;
    assign b           = b_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign blank       = blank_q;
    assign line_start  = lineStart_q;
    assign frame_start = frameStart_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Randomized bench for vga_timing_ctrl on a shrunken raster. Expected outputs come from a
// linear pixel-position model; the RAM is a latency-accurate hash lookup.
module tb_vga_timing_ctrl;
    localparam int H_ACTIVE = 12;
    localparam int H_SYNC   = 4;
    localparam int H_BP     = 3;
    localparam int H_FP     = 2;
    localparam int V_ACTIVE = 6;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 2;
    localparam int V_FP     = 1;
    localparam bit HS_POL   = 1'b1;
    localparam bit VS_POL   = 1'b0;
    localparam int RD_LAT   = 3;
    localparam int CW       = 4;
    localparam int DW       = 3 * CW;
    localparam int H_TOT    = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOT    = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int FRAME    = H_TOT * V_TOT;
    localparam int H_START  = H_SYNC + H_BP;
    localparam int V_START  = V_SYNC + V_BP;
    localparam int FS_DELAY = V_START * H_TOT + H_START + 1 + RD_LAT;

    logic          vga_clk;
    logic          rst;
    logic          en;
    logic [DW-1:0] dIn;
    logic [9:0]    row_addr;
    logic [10:0]   col_addr;
    logic          rdn;
    logic [CW-1:0] r, g, b;
    logic          hs, vs, blank, line_start, frame_start;

    int vectors = 0;
    int miscompares = 0;
    int seed;

    typedef struct {
        logic          rdn;
        logic [9:0]    row;
        logic [10:0]   col;
        logic [CW-1:0] r, g, b;
        logic          hs, vs, blank, ls, fs;
    } rec_t;

    rec_t expQ[$];
    int   pos;
    int   edgeNo;
    bit   statsOn;
    int   hsOnCnt, vsOnCnt, blankLowCnt, lsCnt, fsCnt, fsAligned, fsPeriodBad, lastFsEdge;
    logic prevBlank;

    vga_timing_ctrl #(
        .H_ACTIVE(H_ACTIVE), .H_SYNC(H_SYNC), .H_BP(H_BP), .H_FP(H_FP),
        .V_ACTIVE(V_ACTIVE), .V_SYNC(V_SYNC), .V_BP(V_BP), .V_FP(V_FP),
        .HS_POL(HS_POL), .VS_POL(VS_POL), .RD_LAT(RD_LAT), .CW(CW)
    ) dut (
        .vga_clk(vga_clk), .rst(rst), .en(en), .d_in(dIn),
        .row_addr(row_addr), .col_addr(col_addr), .rdn(rdn),
        .r(r), .g(g), .b(b), .hs(hs), .vs(vs), .blank(blank),
        .line_start(line_start), .frame_start(frame_start)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    function automatic logic [DW-1:0] ramData(input int row, input int col, input int s);
        int h;
        h = (row * 37 + col * 91) ^ s;
        return h[DW-1:0];
    endfunction

    // Pixel RAM: data for an address appears RD_LAT clocks after the address register updates.
    logic [20:0] aPipe [RD_LAT];
    logic [20:0] ramAddr;
    always @(posedge vga_clk) begin
        aPipe[0] <= {row_addr, col_addr};
        for (int i = 1; i < RD_LAT; i++) aPipe[i] <= aPipe[i-1];
    end
    if (RD_LAT == 1) begin : gen_ram_now
        assign ramAddr = {row_addr, col_addr};
    end else begin : gen_ram_late
        assign ramAddr = aPipe[RD_LAT-2];
    end
    assign dIn = ramData(int'(ramAddr[20:11]), int'(ramAddr[10:0]), seed);

    function automatic rec_t idleRec();
        rec_t e;
        e.rdn = 1'b1; e.row = '0; e.col = '0;
        e.r = '0; e.g = '0; e.b = '0;
        e.hs = !HS_POL; e.vs = !VS_POL; e.blank = 1'b1; e.ls = 1'b0; e.fs = 1'b0;
        return e;
    endfunction

    function automatic rec_t pixelRec(input int p, input int s);
        rec_t e;
        int x, y, col, row;
        bit act;
        logic [DW-1:0] d;
        x = p % H_TOT;
        y = p / H_TOT;
        act = (x >= H_START) && (x < H_START + H_ACTIVE) && (y >= V_START) && (y < V_START + V_ACTIVE);
        col = x - H_START;
        row = y - V_START;
        e.rdn = !act;
        e.row = 10'(row);
        e.col = 11'(col);
        e.hs = (x < H_SYNC) ? HS_POL : !HS_POL;
        e.vs = (y < V_SYNC) ? VS_POL : !VS_POL;
        e.blank = !act;
        e.ls = act && (col == 0);
        e.fs = act && (col == 0) && (row == 0);
        d = act ? ramData(row, col, s) : '0;
        e.r = d[CW-1:0];
        e.g = d[2*CW-1:CW];
        e.b = d[3*CW-1:2*CW];
        return e;
    endfunction

    function automatic logic [63:0] packRec(input rec_t e);
        return 64'({e.rdn, e.row, e.col, e.r, e.g, e.b, e.hs, e.vs, e.blank, e.ls, e.fs});
    endfunction

    function automatic logic [63:0] obsPack();
        return 64'({rdn, row_addr, col_addr, r, g, b, hs, vs, blank, line_start, frame_start});
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic compareAll(input rec_t s1, input rec_t s2);
        checkOutput("stage1", 64'({rdn, s1.rdn ? 21'd0 : {row_addr, col_addr}}),
                              64'({s1.rdn, s1.rdn ? 21'd0 : {s1.row, s1.col}}));
        checkOutput("stage2", 64'({r, g, b, hs, vs, blank, line_start, frame_start}),
                              64'({s2.r, s2.g, s2.b, s2.hs, s2.vs, s2.blank, s2.ls, s2.fs}));
    endtask

    task automatic resetModel();
        expQ.delete();
        repeat (RD_LAT) expQ.push_back(idleRec());
        pos = 0;
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare #1 later.
    task automatic stepClock();
        rec_t s1, s2;
        @(posedge vga_clk);
        edgeNo++;
        if (rst) begin
            resetModel();
            s1 = idleRec();
            s2 = idleRec();
        end else begin
            s1 = en ? pixelRec(pos, seed) : idleRec();
            pos = en ? (pos + 1) % FRAME : 0;
            expQ.push_back(s1);
            s2 = expQ.pop_front();
        end
        #1;
        compareAll(s1, s2);
        if (statsOn) begin
            if (hs == HS_POL) hsOnCnt++;
            if (vs == VS_POL) vsOnCnt++;
            if (!blank) blankLowCnt++;
            if (line_start) lsCnt++;
            if (frame_start) begin
                fsCnt++;
                if (line_start && prevBlank && !blank) fsAligned++;
                if (lastFsEdge >= 0 && edgeNo - lastFsEdge != FRAME) fsPeriodBad++;
                lastFsEdge = edgeNo;
            end
        end
        prevBlank = blank;
    endtask

    task automatic applyStimulus(input logic enVal, input int cycles);
        en = enVal;
        repeat (cycles) stepClock();
    endtask

    task automatic waitFrameStart(input string tag, input int expectedEdges);
        int n;
        n = 0;
        do begin
            stepClock();
            n++;
        end while (!frame_start && n < 2 * FRAME);
        checkOutput(tag, 64'(n), 64'(expectedEdges));
    endtask

    task automatic pulseReset();
        #2 rst = 1'b1;
        #1 checkOutput("asyncRstIdle", obsPack(), packRec(idleRec()));
        resetModel();
        stepClock();
        #2 rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        seed = int'($urandom);
        rst = 1'b1;
        en = 1'b0;
        edgeNo = 0;
        statsOn = 1'b0;
        prevBlank = 1'b1;
        resetModel();
        #2 checkOutput("resetIdle", obsPack(), packRec(idleRec()));
        stepClock();
        #2 rst = 1'b0;

        // Three whole frames with stats aligned to the first pixel leaving the pipeline.
        en = 1'b1;
        applyStimulus(1'b1, RD_LAT);
        hsOnCnt = 0; vsOnCnt = 0; blankLowCnt = 0; lsCnt = 0;
        fsCnt = 0; fsAligned = 0; fsPeriodBad = 0; lastFsEdge = -1;
        statsOn = 1'b1;
        applyStimulus(1'b1, 3 * FRAME);
        statsOn = 1'b0;
        checkOutput("hsActiveClocks", 64'(hsOnCnt), 64'(3 * V_TOT * H_SYNC));
        checkOutput("vsActiveClocks", 64'(vsOnCnt), 64'(3 * V_SYNC * H_TOT));
        checkOutput("blankLowClocks", 64'(blankLowCnt), 64'(3 * H_ACTIVE * V_ACTIVE));
        checkOutput("lineStarts", 64'(lsCnt), 64'(3 * V_ACTIVE));
        checkOutput("frameStarts", 64'(fsCnt), 64'(3));
        checkOutput("fsAlignedLsBlank", 64'(fsAligned), 64'(3));
        checkOutput("fsPeriodErrors", 64'(fsPeriodBad), 64'(0));

        // Drop en mid-active, hold it low for 50 clocks, then time the next frame_start.
        for (int n = 0; n < 2 * FRAME && pos != 4 * H_TOT + 10; n++) stepClock();
        applyStimulus(1'b0, RD_LAT + 1);
        checkOutput("idleAfterEnDrop", obsPack(), packRec(idleRec()));
        applyStimulus(1'b0, 50 - (RD_LAT + 1));
        en = 1'b1;
        waitFrameStart("enRestartFs", FS_DELAY);

        // Asynchronous reset between edges while the active area is on the outputs.
        applyStimulus(1'b1, 2 * H_TOT + 3);
        checkOutput("activeBeforeRst", 64'(blank), 64'(0));
        pulseReset();
        waitFrameStart("rstRestartFs", FS_DELAY);

        // Random enable toggling and reset pulses, checked every clock.
        for (int i = 0; i < 12000; i++) begin
            if ($urandom_range(0, 299) == 0) en = !en;
            if ($urandom_range(0, 1999) == 0) pulseReset();
            stepClock();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_timing_ctrl.md
VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

Interface
REQ-001 Parameter H_ACTIVE, 640: visible pixels per line.
REQ-002 Parameters H_SYNC 96, H_BP 48, H_FP 16: horizontal sync, back-porch and front-porch widths in pixels.
REQ-003 Parameter V_ACTIVE, 480: visible lines per frame.
REQ-004 Parameters V_SYNC 2, V_BP 33, V_FP 10: vertical sync, back-porch and front-porch widths in lines.
REQ-005 Parameters HS_POL 0, VS_POL 0: sync assertion level; 0 means active-low.
REQ-006 Parameter RD_LAT, 1, legal range 1..4: pixel RAM read latency in clocks, measured from the address update to d_in valid.
REQ-007 Parameter CW, 4: bits per colour channel.
REQ-008 vga_clk  in  1  pixel clock.
REQ-009 rst  in  1  reset; asynchronous, active-high; the clock is vga_clk.
REQ-010 en  in  1  timing enable; when low, the counters hold at 0.
REQ-011 d_in  in  3*CW  pixel data {b,g,r}, with r in the LSBs.
REQ-012 row_addr  out  10  active line index.
REQ-013 col_addr  out  11  active pixel index.
REQ-014 rdn  out  1  pixel RAM read strobe, active-low.
REQ-015 r, g, b  out  CW each  colour outputs.
REQ-016 hs, vs  out  1 each  sync outputs.
REQ-017 blank  out  1  high outside the active area.
REQ-018 line_start  out  1  one-clock pulse on the first active pixel of each line.
REQ-019 frame_start  out  1  one-clock pulse on the first active pixel of each frame.

Function
REQ-020 Line and frame lengths: H_TOT = H_SYNC+H_BP+H_ACTIVE+H_FP; V_TOT = V_SYNC+V_BP+V_ACTIVE+V_FP.
REQ-021 Horizontal counter hc: counts 0..H_TOT-1 while en=1, then wraps to 0.
REQ-022 Vertical counter vc: increments only on the clock where hc=H_TOT-1, and wraps from V_TOT-1 to 0 on that same clock.
REQ-023 Region order per axis: sync, back porch, active, front porch.
- hsync raw = hc<H_SYNC.
- Horizontal active = H_SYNC+H_BP <= hc < H_SYNC+H_BP+H_ACTIVE.
- The vertical axis follows the same pattern.
REQ-024 Active flag: act = horizontal active AND vertical active.
REQ-025 Address arithmetic: col = hc-(H_SYNC+H_BP), row = vc-(V_SYNC+V_BP); both are unsigned and truncated to the port width.
- Values outside the active area are don't-care, but they SHALL be driven deterministically.
REQ-026 Stage 1: counter state C present before edge k produces row_addr, col_addr and rdn=~act at edge k+1.
REQ-027 Stage 2: hs, vs, blank, line_start, frame_start and r/g/b for C update at edge k+1+RD_LAT. This uses a delay line of RD_LAT stages on the sync and blank flags.
REQ-028 Colour sampling: r/g/b capture d_in on the edge where the delayed act for that pixel is 1; otherwise they load 0.
REQ-029 Sync levels: hs = HS_POL while the delayed hsync raw is 1, else ~HS_POL; vs is the same with VS_POL.
REQ-030 line_start is asserted for the pixel with col=0 and act=1.
REQ-031 frame_start is asserted for the pixel with col=0, row=0 and act=1; it coincides with that line's line_start.
REQ-032 en deasserted at any point:
- hc and vc clear to 0 on the next edge and hold.
- The pipeline continues to flush, so outputs reach the idle state (REQ-035 values) within RD_LAT+1 clocks.
REQ-033 en reasserted: counting restarts at hc=0, vc=0, i.e. at the start of a new frame.
REQ-034 Parameter check: RD_LAT outside 1..4 or any zero-width region SHALL fail elaboration.

Reset
REQ-035 Asynchronous reset (rst high) SHALL immediately force:
- hc=0, vc=0, row_addr=0, col_addr=0, rdn=1;
- r=g=b=0, blank=1;
- hs=~HS_POL, vs=~VS_POL;
- line_start=0, frame_start=0;
- all delay-line stages to these same idle values.
REQ-036 Reset release: counting starts on the first edge after rst falls, provided en=1.
REQ-037 Reset mid-frame: no pulse on line_start or frame_start is emitted until the next genuine active pixel.

Verification
REQ-038 Default parameters, en=1, 2 frames:
- hs low for 96 of 800 clocks per line.
- vs low for 2 lines (1600 clocks) of 525 lines.
- blank low for exactly 640x480 pixels per frame.
REQ-039 Latency check, RD_LAT=3, with a RAM model returning {row[3:0],col[7:0]}: the first active pixel yields r=0, g=0, b=0; col 37, row 5 yields r=5, g=2, b=5. rgb timing is exactly 4 clocks after the hc/vc state.
REQ-040 HS_POL=1, VS_POL=1, H_ACTIVE=800, H_FP=40, H_SYNC=128, H_BP=88:
- H_TOT=1056.
- hs high for 128 clocks.
- line_start period 1056 clocks.
REQ-041 frame_start: one pulse per 420000 clocks (default parameters). Each pulse coincides with line_start and blank falling.
REQ-042 en dropped at hc=300, vc=100 for 50 clocks:
- Outputs idle (REQ-035 values) within RD_LAT+1 clocks.
- After re-enable, frame_start occurs exactly 35x800+144 clocks plus pipeline latency later.
REQ-043 rst pulsed asynchronously between clock edges mid-active: all outputs immediately take the REQ-035 values, and the timing sequence restarts from hc=0, vc=0.
